// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state/owner encodings and counter sizing for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ACCESS = 2'b01, ST_DONE = 2'b10} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;
  function automatic int cnt_width(int w);
    return (w < 2) ? 1 : $clog2(w + 1);
  endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, DMA and memory-side signals of the arbiter
interface mem_arbiter_if #(parameter int AW = 16, parameter int DW = 16);
  logic cpu_rd, cpu_wr, cpu_rdy, dma_req, dma_we, dma_gnt, dma_done, mem_rd, mem_wr, busy;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    output cpu_rdata, cpu_rdy, dma_rdata, dma_gnt, dma_done, mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
    input  cpu_rdata, cpu_rdy, dma_rdata, dma_gnt, dma_done, mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// mem_arbiter_wait_timer: loadable down-counter that stops at zero
module mem_arbiter_wait_timer #(parameter int CW = 2) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] val,
  output logic          zero
);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (en && cnt != '0) cnt <= cnt - CW'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA arbiter that sequences wait-stated single-port memory accesses
module mem_arbiter
  import mem_arbiter_pkg::*;
#(parameter int WAIT_CYCLES = 2) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = cnt_width(WAIT_CYCLES);
  state_t state;
  owner_t owner, last_owner;
  logic cpu_req, win_dma, start, zero;
  assign cpu_req = bus.cpu_rd | bus.cpu_wr;
  assign win_dma = bus.dma_req & (~cpu_req | last_owner == OWN_CPU);
  assign start = state == ST_IDLE && (cpu_req | bus.dma_req);
  mem_arbiter_wait_timer #(.CW(CW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(start),
    .en(state == ST_ACCESS),
    .val(CW'(WAIT_CYCLES)),
    .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= OWN_CPU;
      last_owner <= OWN_DMA;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rd <= 1'b0;
      bus.mem_wr <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dma_rdata <= '0;
      bus.cpu_rdy <= 1'b0;
      bus.dma_done <= 1'b0;
      bus.dma_gnt <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_ACCESS;
          owner <= win_dma ? OWN_DMA : OWN_CPU;
          bus.mem_addr <= win_dma ? bus.dma_addr : bus.cpu_addr;
          bus.mem_wdata <= win_dma ? bus.dma_wdata : bus.cpu_wdata;
          // a CPU cycle with both rd and wr set is a write
          bus.mem_wr <= win_dma ? bus.dma_we : bus.cpu_wr;
          bus.mem_rd <= win_dma ? ~bus.dma_we : ~bus.cpu_wr;
          bus.dma_gnt <= win_dma;
          bus.busy <= 1'b1;
        end
        ST_ACCESS: if (zero) begin
          state <= ST_DONE;
          last_owner <= owner;
          bus.mem_rd <= 1'b0;
          bus.mem_wr <= 1'b0;
          if (bus.mem_rd && owner == OWN_CPU) bus.cpu_rdata <= bus.mem_rdata;
          if (bus.mem_rd && owner == OWN_DMA) bus.dma_rdata <= bus.mem_rdata;
          bus.cpu_rdy <= owner == OWN_CPU;
          bus.dma_done <= owner == OWN_DMA;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          bus.cpu_rdy <= 1'b0;
          bus.dma_done <= 1'b0;
          bus.dma_gnt <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and access sequencer for the multicycle CPU. It shares the single-ported main memory between the CPU controller's memory cycle (memrd/memwr strobes) and a DMA requester. It serialises accesses, inserts a fixed number of wait states and returns a one-cycle completion pulse. The controller stalls its memory state until `cpu_rdy` is high.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `WAIT_CYCLES`, 2, extra memory wait states per access (0 legal)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_rd`  in  1  CPU read request, held until `cpu_rdy`
- `cpu_wr`  in  1  CPU write request, held until `cpu_rdy`
- `cpu_addr`  in  AW  CPU address (MAR)
- `cpu_wdata`  in  DW  CPU write data (MDR)
- `cpu_rdata`  out  DW  registered CPU read data
- `cpu_rdy`  out  1  one-cycle CPU completion pulse
- `dma_req`  in  1  DMA request, held until `dma_done`
- `dma_we`  in  1  DMA write (1) / read (0)
- `dma_addr`  in  AW  DMA address
- `dma_wdata`  in  DW  DMA write data
- `dma_rdata`  out  DW  registered DMA read data
- `dma_gnt`  out  1  DMA owns memory
- `dma_done`  out  1  one-cycle DMA completion pulse
- `mem_addr`  out  AW  registered memory address
- `mem_wdata`  out  DW  registered memory write data
- `mem_rd`  out  1  memory read strobe
- `mem_wr`  out  1  memory write strobe
- `mem_rdata`  in  DW  memory read data, valid on last ACCESS cycle
- `busy`  out  1  arbiter not in IDLE

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE arbitration:**
  - CPU request = `cpu_rd | cpu_wr`; DMA request = `dma_req`.
  - Only one requester: that requester wins.
  - Both request: round-robin. The requester not served last wins.
  - `last_owner` resets to DMA, so the CPU wins the first tie.
- **IDLE → ACCESS:**
  - Latch owner, address, write data and direction into output registers.
  - Load `wcnt = WAIT_CYCLES`.
  - `cpu_wr` and `cpu_rd` both high is treated as a write.
- **ACCESS:**
  - `mem_rd` or `mem_wr` held high.
  - `mem_addr` and `mem_wdata` held stable.
  - `wcnt` decrements each cycle.
  - When `wcnt == 0`: capture `mem_rdata` into the owner's rdata register (reads only), deassert strobes, update `last_owner`, go to DONE.
- **DONE:**
  - Pulse `cpu_rdy` or `dma_done` for exactly one cycle.
  - Return to IDLE.
  - Re-arbitration happens in IDLE on the next cycle.
- **Request hold:** a request still held in IDLE after its completion pulse starts a new transaction. Requesters must drop the request the cycle after the pulse.
- **Request withdrawn mid-ACCESS:** the transaction completes, and the completion pulse is still issued.
- **Input changes during ACCESS/DONE:** address and data changes are ignored.
- **`dma_gnt`:** high in ACCESS and DONE when DMA is the owner.
- **`busy`:** high in ACCESS and DONE.
- **Reset (synchronous `rst`), including mid-ACCESS:** the access aborts with no completion pulse. At the clock edge where `rst` is sampled high:
  - State returns to IDLE and `last_owner` returns to DMA.
  - All outputs go to 0: strobes, `cpu_rdy`, `dma_done`, `dma_gnt`, `busy`, `mem_addr`, `mem_wdata`, `cpu_rdata`, `dma_rdata`.

## Timing
- All outputs are registered, with no combinational input→output path.
- Request first sampled high at edge E0:
  - ACCESS spans edges E0+1 … E0+1+WAIT_CYCLES.
  - DONE pulse at E0+2+WAIT_CYCLES.
  - Memory strobe width = WAIT_CYCLES+1 cycles.
- Per-access latency, request to completion pulse = WAIT_CYCLES+2 cycles.
- Back-to-back throughput: one access every WAIT_CYCLES+3 cycles (IDLE, ACCESS×(W+1), DONE).
- `cpu_rdata` / `dma_rdata` are valid from the completion-pulse cycle and hold until the owner's next read completes.
- The counter width is enough to hold `WAIT_CYCLES`. `WAIT_CYCLES=0` gives a single-cycle ACCESS.

## Structure
- **Shared definitions header `mem_arb_defs.vh`:**
  - State encodings ST_IDLE=2'b00, ST_ACCESS=2'b01, ST_DONE=2'b10.
  - Owner encodings OWN_CPU=1'b0, OWN_DMA=1'b1.
  - Included by `mem_arbiter` and the controller bench.
- **Sub-module `wait_timer`:** loadable down-counter with `load`, `en` and a `zero` flag. Used by ACCESS.
- **Top-level contents:** FSM, round-robin bit, output registers.

## Test plan
- **CPU read alone:** WAIT_CYCLES=2, `cpu_rd=1`, `cpu_addr=16'h0040`, memory returns 16'hBEEF.
  - `mem_rd` high 3 cycles at `mem_addr` 16'h0040.
  - `cpu_rdy` pulses 4 cycles after the request.
  - `cpu_rdata=16'hBEEF`.
- **DMA write alone:** `dma_we=1`, `dma_addr=16'h0100`, `dma_wdata=16'h1234`.
  - `dma_gnt` high 4 cycles.
  - `mem_wr` high 3 cycles with 16'h1234.
  - `dma_done` pulses once; CPU outputs unaffected.
- **Simultaneous requests from reset, both held:**
  - Service order CPU, DMA, CPU, DMA.
  - Completion pulses spaced 5 cycles apart.
- **WAIT_CYCLES=0, CPU write:**
  - `mem_wr` high exactly 1 cycle.
  - `cpu_rdy` at request+2.
- **`rst` asserted in the second ACCESS cycle of a DMA read:**
  - Next edge: `mem_rd=0`, `busy=0`, no `dma_done`.
  - Subsequent tie is won by the CPU.
- **CPU drops `cpu_rd` mid-ACCESS:**
  - Access still runs to completion.
  - `cpu_rdy` pulses once.
  - IDLE is entered and stays idle with no further strobes.
